// File: rtl/perf_bcd_conv.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per clock) with a
// start/busy/done handshake and an overflow flag for digits beyond DIGITS.
module perf_bcd_conv #(
  parameter int unsigned BIN_W      = 32,
  parameter int unsigned INT_DIGITS = 10,
  parameter int unsigned DIGITS     = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   digits,
  output logic                  overflow
);

  localparam int unsigned ACC_W = 4 * INT_DIGITS;
  localparam int unsigned DIG_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [BIN_W-1:0]   sr_q, sr_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [DIG_W-1:0]   digits_q, digits_d;
  logic               overflow_q, overflow_d;

  logic [ACC_W-1:0]   acc_adj_c;
  logic [ACC_W-1:0]   acc_shf_c;
  logic [BIN_W-1:0]   sr_shf_c;
  logic               ovf_c;

  // Add-3 on every nibble >= 5, then shift {acc,sr} left by one.
  always_comb begin
    acc_adj_c = acc_q;
    for (int unsigned i = 0; i < INT_DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) begin
        acc_adj_c[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
    end
    acc_shf_c = ACC_W'({acc_adj_c, sr_q[BIN_W-1]});
    sr_shf_c  = {sr_q[BIN_W-2:0], 1'b0};
    ovf_c = 1'b0;
    for (int unsigned i = DIGITS; i < INT_DIGITS; i++) begin
      ovf_c = ovf_c | (|acc_shf_c[4*i +: 4]);
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    digits_d   = digits_q;
    overflow_d = overflow_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_SHIFT;
          sr_d    = bin;
          acc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        sr_d   = sr_shf_c;
        acc_d  = acc_shf_c;
        cnt_d  = cnt_q + CNT_W'(1);
        busy_d = 1'b1;
        if (cnt_q == LAST_CNT) begin
          state_d    = S_DONE;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          digits_d   = acc_shf_c[DIG_W-1:0];
          overflow_d = ovf_c;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      sr_q       <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      digits_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      digits_q   <= digits_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign digits   = digits_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_perf_bcd_conv.sv
// Self-checking bench for perf_bcd_conv: directed handshake/timing scenarios
// plus randomized values against an arithmetic decimal model.
module tb_perf_bcd_conv;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] bin;
  logic        busy;
  logic        done;
  logic [23:0] digits;
  logic        overflow;

  int errors = 0;
  int checks = 0;
  bit mon_en = 0;

  perf_bcd_conv dut (
    .clk      (clk),
    .rst      (rst_n),
    .start    (start),
    .bin      (bin),
    .busy     (busy),
    .done     (done),
    .digits   (digits),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decimal reference: low six digits of v as packed BCD.
  function automatic logic [23:0] model_digits(input logic [31:0] v);
    logic [23:0] res;
    longint unsigned r;
    res = '0;
    r = longint'(v) % 64'd1000000;
    for (int d = 0; d < 6; d++) begin
      res[4*d +: 4] = 4'(r % 10);
      r = r / 10;
    end
    return res;
  endfunction

  function automatic logic model_ovf(input logic [31:0] v);
    return (longint'(v) >= 64'd1000000);
  endfunction

  // Per-cycle invariants: legal BCD nibbles and busy/done exclusive.
  always @(negedge clk) begin
    if (mon_en) begin
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < 6; i++) begin
        if (digits[4*i +: 4] > 4'd9) bad = 1'b1;
      end
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL nibble_range t=%0t digits=%h required all nibbles <=9", $time, digits);
      end
      checks++;
      if (done && busy) begin
        errors++;
        $display("FAIL busy_done_excl t=%0t busy=%b done=%b required not both 1", $time, busy, done);
      end
    end
  end

  // Issue one start pulse and wait (bounded) for done; returns observations.
  task automatic run_conv(input logic [31:0] v, output logic [23:0] d, output logic o,
                          output int busy_cycles, output bit timed_out);
    int cyc;
    @(negedge clk);
    start = 1'b1;
    bin   = v;
    @(negedge clk);
    start = 1'b0;
    bin   = $urandom;
    busy_cycles = 0;
    cyc = 0;
    while (!done && cyc < 200) begin
      if (busy) busy_cycles++;
      @(negedge clk);
      cyc++;
    end
    timed_out = !done;
    d = digits;
    o = overflow;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    bin   = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, overflow} !== 3'b000 || digits !== 24'h0) begin
      errors++;
      $display("FAIL reset_state busy=%b done=%b ovf=%b digits=%h required 0 0 0 000000",
               busy, done, overflow, digits);
    end
    rst_n = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic test_zero();
    logic [23:0] d; logic o; int bc; bit to;
    run_conv(32'd0, d, o, bc, to);
    checks++;
    if (to) begin errors++; $display("FAIL zero_timeout done never seen required done"); end
    checks++;
    if (bc !== 32) begin errors++; $display("FAIL zero_busy_len busy_cycles=%0d required 32", bc); end
    checks++;
    if (d !== 24'h0 || o !== 1'b0) begin
      errors++; $display("FAIL zero_result digits=%h ovf=%b required 000000 0", d, o);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL zero_done_pulse done=%b busy=%b required 0 0", done, busy);
    end
  endtask

  task automatic test_values();
    logic [31:0] vals [4];
    logic [23:0] d; logic o; int bc; bit to;
    vals[0] = 32'd123456; vals[1] = 32'd999999; vals[2] = 32'd1000000; vals[3] = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      run_conv(vals[i], d, o, bc, to);
      checks++;
      if (to || d !== model_digits(vals[i]) || o !== model_ovf(vals[i])) begin
        errors++;
        $display("FAIL value_%0d bin=%0d digits=%h ovf=%b timeout=%b required %h %b",
                 i, vals[i], d, o, to, model_digits(vals[i]), model_ovf(vals[i]));
      end
    end
    checks++;
    if (d !== 24'h967295) begin errors++; $display("FAIL max_digits digits=%h required 967295", d); end
  endtask

  task automatic test_ignore_start();
    int cyc; int extra;
    @(negedge clk);
    start = 1'b1; bin = 32'd42;
    @(negedge clk);
    start = 1'b0; bin = $urandom;
    repeat (9) @(negedge clk);
    start = 1'b1; bin = 32'd7;
    @(negedge clk);
    start = 1'b0; bin = $urandom;
    cyc = 0;
    while (!done && cyc < 100) begin @(negedge clk); cyc++; end
    checks++;
    if (!done || digits !== 24'h000042 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL ignore_result done=%b digits=%h ovf=%b required 1 000042 0", done, digits, overflow);
    end
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) extra++;
    end
    checks++;
    if (extra !== 0) begin errors++; $display("FAIL ignore_single_done extra_dones=%0d required 0", extra); end
  endtask

  task automatic test_back_to_back();
    int cyc; int gap;
    @(negedge clk);
    start = 1'b1; bin = 32'd7;
    cyc = 0;
    @(negedge clk);
    while (!done && cyc < 100) begin @(negedge clk); cyc++; end
    checks++;
    if (!done || digits !== 24'h000007) begin
      errors++; $display("FAIL b2b_first done=%b digits=%h required 1 000007", done, digits);
    end
    gap = 0;
    @(negedge clk); gap++;
    while (!done && gap < 100) begin @(negedge clk); gap++; end
    start = 1'b0;
    checks++;
    if (gap !== 33) begin errors++; $display("FAIL b2b_gap cycles=%0d required 33", gap); end
    checks++;
    if (digits !== 24'h000007 || overflow !== 1'b0) begin
      errors++; $display("FAIL b2b_second digits=%h ovf=%b required 000007 0", digits, overflow);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [23:0] d; logic o; int bc; bit to; int seen;
    run_conv(32'd555, d, o, bc, to);
    checks++;
    if (to || d !== 24'h000555) begin errors++; $display("FAIL rst_pre digits=%h required 000555", d); end
    @(negedge clk);
    start = 1'b1; bin = 32'd888;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (digits !== 24'h0 || busy !== 1'b0 || done !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid digits=%h busy=%b done=%b ovf=%b required 000000 0 0 0",
               digits, busy, done, overflow);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL rst_no_done activity_cycles=%0d required 0", seen); end
    run_conv(32'd31415, d, o, bc, to);
    checks++;
    if (to || d !== 24'h031415 || o !== 1'b0) begin
      errors++; $display("FAIL rst_post digits=%h ovf=%b required 031415 0", d, o);
    end
  endtask

  task automatic test_random();
    logic [31:0] v; logic [23:0] d; logic o; int bc; bit to;
    for (int n = 0; n < 1000; n++) begin
      case ($urandom_range(0, 3))
        0:       v = $urandom_range(0, 2000000);
        1:       v = $urandom_range(0, 9999);
        default: v = $urandom;
      endcase
      run_conv(v, d, o, bc, to);
      checks++;
      if (to || bc !== 32 || d !== model_digits(v) || o !== model_ovf(v)) begin
        errors++;
        $display("FAIL rand_%0d bin=%0d digits=%h ovf=%b busy=%0d timeout=%b required %h %b 32",
                 n, v, d, o, bc, to, model_digits(v), model_ovf(v));
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_values();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/perf_bcd_conv.md
# perf_bcd_conv

Sequential binary-to-BCD converter between the TSP solver's 32-bit `performance` result and the six seven-segment digit decoders on the board top. It replaces per-digit `/10^n % 10` arithmetic with a shift-add-3 (double-dabble) engine that processes one bit per clock. On each start request it captures one binary sample and later presents the low `DIGITS` decimal digits, plus an overflow flag, through a start/busy/done handshake.

## Interface

- `BIN_W`, 32: width of the binary input.
- `INT_DIGITS`, 10: internal BCD digits; must satisfy 10^INT_DIGITS > 2^BIN_W (10 for 32 bits).
- `DIGITS`, 6: decimal digits presented on `digits`; must be ≤ INT_DIGITS.

Ports:

- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request a conversion of `bin`; honoured only when `busy`=0.
- `bin`  in  BIN_W  unsigned value; sampled only on the accepting edge.
- `busy`  out  1  conversion in progress.
- `done`  out  1  one-cycle pulse: `digits`/`overflow` just updated.
- `digits`  out  4*DIGITS  BCD result; digit 0 (units) in [3:0], digit n in [4n+3:4n].
- `overflow`  out  1  the captured value ≥ 10^DIGITS, so `digits` shows value mod 10^DIGITS.

## Operation

- Datapath: shift register `sr` of BIN_W bits, BCD accumulator `acc` of 4*INT_DIGITS bits, and bit counter `cnt` of ceil(log2(BIN_W+1)) bits.
- State machine with states IDLE, SHIFT and DONE:
  - **IDLE**: `busy`=0. If `start`=1: `sr`←`bin`, `acc`←0, `cnt`←0, go to SHIFT.
  - **SHIFT**: `busy`=1. Each edge:
    - every `acc` nibble ≥5 gets +3 (all nibbles in parallel, combinationally);
    - then {`acc`,`sr`} shifts left by 1 with the MSB of `sr` entering `acc[0]`;
    - `cnt`++.
    - The edge that performs the BIN_W-th shift goes to DONE.
  - **DONE**: `busy`=0. On entry edge, `digits`←`acc[4*DIGITS-1:0]` and `overflow`←(|`acc[4*INT_DIGITS-1:4*DIGITS]`). `done`=1 for this single cycle.
    - If `start`=1 in DONE: accept as from IDLE (back-to-back conversions).
    - Otherwise go to IDLE.
- The adjust step operates on the pre-shift `acc` each cycle. No adjust is applied after the final shift.
- `start` while `busy`=1 is ignored; it is not queued. `bin` changes while busy have no effect.
- `digits` and `overflow` hold their last result indefinitely and change only on DONE entry.
- Every nibble of `digits` is always in the range 0..9.
- Reset (`rst`=0, at any time, including mid-SHIFT): state→IDLE, `busy`=0, `done`=0, `digits`=0, `overflow`=0, `acc`=0, `sr`=0, `cnt`=0. An aborted conversion produces no `done`.

## Timing

- Let edge k be the accepting edge (`start`=1, `busy`=0).
- Cycles after edges k .. k+BIN_W-1: `busy`=1 (BIN_W cycles; 32 by default).
- Edge k+BIN_W: last shift, enter DONE. The cycle after it has `done`=1, `busy`=0, and the new `digits`/`overflow` visible.
- Latency from the start edge to `done` visible: BIN_W edges. Throughput: one conversion per BIN_W+1 cycles when `start` is held high.
- Reset assertion clears outputs immediately (asynchronous). After deassertion, the first accepting edge can be the first rising edge at which `rst`=1.

## Test plan

- Reset then `bin`=0 with a start pulse -> `busy` high exactly 32 cycles, then `done` for 1 cycle; `digits`=0x000000, `overflow`=0.
- `bin`=123456 -> `digits`=0x123456, `overflow`=0; `bin`=999999 -> `digits`=0x999999, `overflow`=0.
- `bin`=1000000 -> `digits`=0x000000, `overflow`=1; `bin`=0xFFFFFFFF (4294967295) -> `digits`=0x967295, `overflow`=1.
- Start `bin`=42, pulse `start` again with `bin`=7 at cycle 10 of busy -> a single `done`, `digits`=0x000042. Then hold `start`=1 with `bin`=7 -> next `done` exactly 33 cycles after the previous one, `digits`=0x000007.
- Complete a conversion of 555 (`digits`=0x000555), then start `bin`=888 and assert `rst`=0 at busy cycle 16 -> `digits`=0, `busy`=0, no `done`. After release, converting 31415 gives 0x031415.
- Randomised: 1000 random `bin` values compared against a model of `bin % 10^6` and `bin ≥ 10^6`. In every cycle, check that every nibble of `digits` is ≤9 and that `done` and `busy` are never both high.
